// File: rtl/soin_gshare_bpredictor_if.sv
// Fetch/execute bundle for soin_gshare_bpredictor.
// master = fetch+execute side, slave = predictor; stats ports need BP_STATS_EN.
interface soin_gshare_bpredictor_if #(
  parameter int META_W = 15
);
  logic              soin_bpredictor_stall;
  logic [31:0]       fetch_bpredictor_PC;
  logic [31:0]       bpredictor_fetch_p_target;
  logic              bpredictor_fetch_p_dir;
  logic [META_W-1:0] bpredictor_fetch_meta;
  logic              bpredictor_busy;
  logic              execute_bpredictor_update;
  logic [31:0]       execute_bpredictor_PC;
  logic [31:0]       execute_bpredictor_target;
  logic              execute_bpredictor_dir;
  logic              execute_bpredictor_miss;
  logic [META_W-1:0] execute_bpredictor_meta;
`ifdef BP_STATS_EN
  logic [31:0]       stat_updates;
  logic [31:0]       stat_misses;
`endif

  modport master (
`ifdef BP_STATS_EN
    input  stat_updates,
    input  stat_misses,
`endif
    output soin_bpredictor_stall,
    output fetch_bpredictor_PC,
    input  bpredictor_fetch_p_target,
    input  bpredictor_fetch_p_dir,
    input  bpredictor_fetch_meta,
    input  bpredictor_busy,
    output execute_bpredictor_update,
    output execute_bpredictor_PC,
    output execute_bpredictor_target,
    output execute_bpredictor_dir,
    output execute_bpredictor_miss,
    output execute_bpredictor_meta
  );

  modport slave (
`ifdef BP_STATS_EN
    output stat_updates,
    output stat_misses,
`endif
    input  soin_bpredictor_stall,
    input  fetch_bpredictor_PC,
    output bpredictor_fetch_p_target,
    output bpredictor_fetch_p_dir,
    output bpredictor_fetch_meta,
    output bpredictor_busy,
    input  execute_bpredictor_update,
    input  execute_bpredictor_PC,
    input  execute_bpredictor_target,
    input  execute_bpredictor_dir,
    input  execute_bpredictor_miss,
    input  execute_bpredictor_meta
  );
endinterface

// File: rtl/soin_gshare_bpredictor.sv
// gshare/bimodal direction predictor with direct-mapped tagged BTB.
// Ports: clk, reset (sync, active-high), bp (slave); BP_STATS_EN adds stats.
module soin_gshare_bpredictor #(
  parameter int PHT_DEPTH_L = 12,
  parameter int BTB_DEPTH_L = 8,
  parameter int CTR_WIDTH   = 2,
  parameter int GHR_WIDTH   = 10,
  parameter int TAG_WIDTH   = 10,
  parameter int GSHARE      = 1
) (
  input logic clk,
  input logic reset,
  soin_gshare_bpredictor_if.slave bp
);
  localparam int META_W = PHT_DEPTH_L + CTR_WIDTH + 1;
  localparam int CNT_L  = (PHT_DEPTH_L > BTB_DEPTH_L) ?
                          PHT_DEPTH_L : BTB_DEPTH_L;
  localparam int PHT_N  = 1 << PHT_DEPTH_L;
  localparam int BTB_N  = 1 << BTB_DEPTH_L;
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT =
    CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                 state;
  logic [CNT_L-1:0]       cnt;
  logic                   busy;
  logic [GHR_WIDTH-1:0]   ghr;
  logic [GHR_WIDTH-1:0]   ghr_n;

  logic [CTR_WIDTH-1:0]   pht     [PHT_N];
  logic                   btb_v   [BTB_N];
  logic [TAG_WIDTH-1:0]   btb_tag [BTB_N];
  logic [31:0]            btb_tgt [BTB_N];

  logic                   lk_en;
  logic [PHT_DEPTH_L-1:0] lk_idx;
  logic [BTB_DEPTH_L-1:0] lk_bidx;
  logic [CTR_WIDTH-1:0]   pht_rd;
  logic                   v_rd;
  logic [TAG_WIDTH-1:0]   tag_rd;
  logic [31:0]            tgt_rd;

  logic                   lk_valid;
  logic                   lk_busy;
  logic [31:0]            lk_pc;
  logic [PHT_DEPTH_L-1:0] lk_idx_q;
  logic [TAG_WIDTH-1:0]   lk_tag;

  logic                   acc;
  logic [PHT_DEPTH_L-1:0] u_idx;
  logic [CTR_WIDTH-1:0]   u_ctr;
  logic [CTR_WIDTH-1:0]   u_ctr_n;
  logic [BTB_DEPTH_L-1:0] u_bidx;

  logic                   pht_ok;
  logic                   btb_ok;
  logic                   pht_we;
  logic [PHT_DEPTH_L-1:0] pht_wa;
  logic [CTR_WIDTH-1:0]   pht_wd;
  logic                   btb_we;
  logic                   btb_fill;
  logic [BTB_DEPTH_L-1:0] btb_wa;

  logic                   hit;
  logic                   p_dir;

  // Sweep entries past a smaller table's depth are skipped
  if (CNT_L > PHT_DEPTH_L) begin : g_pht_ok
    assign pht_ok = ~|cnt[CNT_L-1:PHT_DEPTH_L];
  end else begin : g_pht_all
    assign pht_ok = 1'b1;
  end
  if (CNT_L > BTB_DEPTH_L) begin : g_btb_ok
    assign btb_ok = ~|cnt[CNT_L-1:BTB_DEPTH_L];
  end else begin : g_btb_all
    assign btb_ok = 1'b1;
  end

  if (GHR_WIDTH > 1) begin : g_ghr
    assign ghr_n = {ghr[GHR_WIDTH-2:0], bp.execute_bpredictor_dir};
  end else begin : g_ghr1
    assign ghr_n = bp.execute_bpredictor_dir;
  end

  always_comb begin
    lk_idx = bp.fetch_bpredictor_PC[PHT_DEPTH_L+1:2];
    if (GSHARE != 0)
      lk_idx = lk_idx ^ PHT_DEPTH_L'(ghr);
  end

  assign lk_en   = ~bp.soin_bpredictor_stall;
  assign lk_bidx = bp.fetch_bpredictor_PC[BTB_DEPTH_L+1:2];

  // Updates only land in RUN; anything arriving during the sweep is dropped
  assign acc    = bp.execute_bpredictor_update & ~reset &
                  (state == S_RUN);
  assign u_idx  = bp.execute_bpredictor_meta[PHT_DEPTH_L-1:0];
  assign u_ctr  = bp.execute_bpredictor_meta[PHT_DEPTH_L +: CTR_WIDTH];
  assign u_bidx = bp.execute_bpredictor_PC[BTB_DEPTH_L+1:2];

  // Counter comes back in meta, so no read-modify-write of the PHT
  always_comb begin
    u_ctr_n = u_ctr;
    if (bp.execute_bpredictor_dir) begin
      if (u_ctr != CTR_MAX) u_ctr_n = u_ctr + 1'b1;
    end else begin
      if (u_ctr != '0) u_ctr_n = u_ctr - 1'b1;
    end
  end

  always_comb begin
    pht_we   = 1'b0;
    pht_wa   = u_idx;
    pht_wd   = u_ctr_n;
    btb_we   = 1'b0;
    btb_fill = 1'b0;
    btb_wa   = u_bidx;
    if (state == S_INIT) begin
      pht_we = pht_ok;
      pht_wa = cnt[PHT_DEPTH_L-1:0];
      pht_wd = CTR_INIT;
      btb_we = btb_ok;
      btb_wa = cnt[BTB_DEPTH_L-1:0];
    end else if (acc) begin
      pht_we   = 1'b1;
      btb_we   = bp.execute_bpredictor_dir;
      btb_fill = bp.execute_bpredictor_dir;
    end
  end

  // Read-before-write: a same-cycle lookup sees the old entry
  always_ff @(posedge clk) begin
    if (pht_we) pht[pht_wa] <= pht_wd;
    if (lk_en) pht_rd <= pht[lk_idx];
  end

  always_ff @(posedge clk) begin
    if (btb_we) btb_v[btb_wa] <= btb_fill;
    if (lk_en) v_rd <= btb_v[lk_bidx];
  end

  always_ff @(posedge clk) begin
    if (btb_fill) begin
      btb_tag[btb_wa] <=
        bp.execute_bpredictor_PC[BTB_DEPTH_L+2 +: TAG_WIDTH];
      btb_tgt[btb_wa] <= bp.execute_bpredictor_target;
    end
    if (lk_en) begin
      tag_rd <= btb_tag[lk_bidx];
      tgt_rd <= btb_tgt[lk_bidx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lk_valid <= 1'b0;
      lk_busy  <= 1'b1;
      lk_pc    <= '0;
      lk_idx_q <= '0;
      lk_tag   <= '0;
    end else if (lk_en) begin
      lk_valid <= 1'b1;
      lk_busy  <= busy;
      lk_pc    <= bp.fetch_bpredictor_PC;
      lk_idx_q <= lk_idx;
      lk_tag   <= bp.fetch_bpredictor_PC[BTB_DEPTH_L+2 +: TAG_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_INIT;
      cnt   <= '0;
      busy  <= 1'b1;
      ghr   <= '0;
    end else begin
      unique case (state)
        S_INIT: begin
          cnt <= cnt + 1'b1;
          if (&cnt) begin
            state <= S_RUN;
            busy  <= 1'b0;
          end
        end
        S_RUN: if (acc) ghr <= ghr_n;
        default: ;
      endcase
    end
  end

  // Lookup state is frozen by stall, so outputs hold with it
  assign hit   = lk_valid & v_rd & (tag_rd == lk_tag);
  assign p_dir = hit & pht_rd[CTR_WIDTH-1] & ~lk_busy;

  assign bp.bpredictor_busy           = busy;
  assign bp.bpredictor_fetch_p_dir    = p_dir;
  assign bp.bpredictor_fetch_p_target =
    ~lk_valid ? 32'h0 : (p_dir ? tgt_rd : lk_pc + 32'd4);
  assign bp.bpredictor_fetch_meta     =
    lk_valid ? META_W'({hit, pht_rd, lk_idx_q}) : '0;

`ifdef BP_STATS_EN
  logic [31:0] n_upd;
  logic [31:0] n_miss;

  always_ff @(posedge clk) begin
    if (reset) begin
      n_upd  <= '0;
      n_miss <= '0;
    end else if (acc) begin
      n_upd <= n_upd + 32'd1;
      if (bp.execute_bpredictor_miss) n_miss <= n_miss + 32'd1;
    end
  end

  assign bp.stat_updates = n_upd;
  assign bp.stat_misses  = n_miss;
`endif

  logic unused_sink;
  assign unused_sink = ^{bp.fetch_bpredictor_PC,
                         bp.execute_bpredictor_PC,
                         bp.execute_bpredictor_meta,
                         bp.execute_bpredictor_miss, ghr};
endmodule

// File: tb/tb_soin_gshare_bpredictor.sv
// Directed bench for soin_gshare_bpredictor: bimodal and gshare instances.
// Stats checks compile in with BP_STATS_EN.
module tb_soin_gshare_bpredictor;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  soin_gshare_bpredictor_if #(.META_W(15)) bif ();
  soin_gshare_bpredictor_if #(.META_W(15)) gif ();

  soin_gshare_bpredictor #(.GSHARE(0)) u_bim (
    .clk(clk), .reset(reset), .bp(bif.slave));
  soin_gshare_bpredictor #(.GSHARE(1)) u_gs (
    .clk(clk), .reset(reset), .bp(gif.slave));

  int checks = 0;
  int errors = 0;
  int n;
  logic [1:0] c;
`ifdef BP_STATS_EN
  int exp_upd = 0;
  int exp_miss = 0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt,
                     input logic dir, input logic miss,
                     input logic [14:0] meta);
    bif.execute_bpredictor_update = 1'b1;
    bif.execute_bpredictor_PC     = pc;
    bif.execute_bpredictor_target = tgt;
    bif.execute_bpredictor_dir    = dir;
    bif.execute_bpredictor_miss   = miss;
    bif.execute_bpredictor_meta   = meta;
    tick();
    bif.execute_bpredictor_update = 1'b0;
`ifdef BP_STATS_EN
    exp_upd++;
    if (miss) exp_miss++;
`endif
  endtask

  // Counts busy cycles from the current sample; optional dropped update
  task automatic wait_init(input int n0, input int drop_at,
                           output int cnt);
    cnt = n0;
    while (bif.bpredictor_busy && cnt < 10000) begin
      cnt++;
      if (cnt == drop_at) begin
        bif.execute_bpredictor_update = 1'b1;
        bif.execute_bpredictor_PC     = 32'h100;
        bif.execute_bpredictor_target = 32'h400;
        bif.execute_bpredictor_dir    = 1'b1;
        bif.execute_bpredictor_miss   = 1'b1;
        bif.execute_bpredictor_meta   = 15'h1040;
      end else begin
        bif.execute_bpredictor_update = 1'b0;
      end
      tick();
    end
    bif.execute_bpredictor_update = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bif.soin_bpredictor_stall     = 1'b0;
    bif.fetch_bpredictor_PC       = 32'h100;
    bif.execute_bpredictor_update = 1'b0;
    bif.execute_bpredictor_PC     = '0;
    bif.execute_bpredictor_target = '0;
    bif.execute_bpredictor_dir    = 1'b0;
    bif.execute_bpredictor_miss   = 1'b0;
    bif.execute_bpredictor_meta   = '0;
    gif.soin_bpredictor_stall     = 1'b0;
    gif.fetch_bpredictor_PC       = 32'h0;
    gif.execute_bpredictor_update = 1'b0;
    gif.execute_bpredictor_PC     = '0;
    gif.execute_bpredictor_target = '0;
    gif.execute_bpredictor_dir    = 1'b0;
    gif.execute_bpredictor_miss   = 1'b0;
    gif.execute_bpredictor_meta   = '0;

    tick(); tick(); tick();
    chk("rst_busy", 32'(bif.bpredictor_busy), 32'd1);
    chk("rst_dir", 32'(bif.bpredictor_fetch_p_dir), 32'd0);
    chk("rst_tgt", bif.bpredictor_fetch_p_target, 32'h0);
    chk("rst_meta", 32'(bif.bpredictor_fetch_meta), 32'h0);
    chk("rst_gmeta", 32'(gif.bpredictor_fetch_meta), 32'h0);

    reset = 1'b0;
    tick();
    chk("busy_dir", 32'(bif.bpredictor_fetch_p_dir), 32'd0);
    chk("busy_tgt", bif.bpredictor_fetch_p_target, 32'h104);
    wait_init(1, -1, n);
    chk("busy_len", 32'(n), 32'd4096);
    tick();
    chk("init_meta", 32'(bif.bpredictor_fetch_meta), 32'h1040);
    chk("init_dir", 32'(bif.bpredictor_fetch_p_dir), 32'd0);
    chk("init_tgt", bif.bpredictor_fetch_p_target, 32'h104);
`ifdef BP_STATS_EN
    chk("st0_upd", bif.stat_updates, 32'd0);
    chk("st0_miss", bif.stat_misses, 32'd0);
`endif

    upd(32'h100, 32'h400, 1'b1, 1'b1, 15'h1040);
    tick();
    chk("t1_meta", 32'(bif.bpredictor_fetch_meta), 32'h6040);
    chk("t1_dir", 32'(bif.bpredictor_fetch_p_dir), 32'd1);
    chk("t1_tgt", bif.bpredictor_fetch_p_target, 32'h400);
    upd(32'h100, 32'h400, 1'b1, 1'b0, 15'h6040);
    tick();
    chk("t2_meta", 32'(bif.bpredictor_fetch_meta), 32'h7040);
    chk("t2_dir", 32'(bif.bpredictor_fetch_p_dir), 32'd1);
    chk("t2_tgt", bif.bpredictor_fetch_p_target, 32'h400);

    c = 2'd3;
    for (int i = 0; i < 4; i++) begin
      upd(32'h100, 32'h400, 1'b1, 1'b0, {1'b1, c, 12'h040});
      if (c != 2'd3) c = c + 2'd1;
    end
    tick();
    chk("sat_hi_meta", 32'(bif.bpredictor_fetch_meta), 32'h7040);
    for (int i = 0; i < 5; i++) begin
      upd(32'h100, 32'h400, 1'b0, 1'b1, {1'b1, c, 12'h040});
      if (c != 2'd0) c = c - 2'd1;
    end
    tick();
    chk("sat_lo_meta", 32'(bif.bpredictor_fetch_meta), 32'h4040);
    chk("sat_lo_dir", 32'(bif.bpredictor_fetch_p_dir), 32'd0);
    chk("sat_lo_tgt", bif.bpredictor_fetch_p_target, 32'h104);

    upd(32'h100, 32'h400, 1'b1, 1'b0, 15'h4040);
    upd(32'h100, 32'h400, 1'b1, 1'b0, 15'h5040);
    upd(32'h100, 32'h400, 1'b1, 1'b0, 15'h1140);
    tick();
    chk("tr_meta", 32'(bif.bpredictor_fetch_meta), 32'h6040);
    chk("tr_dir", 32'(bif.bpredictor_fetch_p_dir), 32'd1);
    bif.fetch_bpredictor_PC = 32'h500;
    tick();
    chk("al_meta", 32'(bif.bpredictor_fetch_meta), 32'h2140);
    chk("al_dir", 32'(bif.bpredictor_fetch_p_dir), 32'd0);
    chk("al_tgt", bif.bpredictor_fetch_p_target, 32'h504);

    bif.soin_bpredictor_stall = 1'b1;
    bif.fetch_bpredictor_PC   = 32'h100;
    upd(32'h500, 32'h0, 1'b0, 1'b1, 15'h2140);
    chk("st1_meta", 32'(bif.bpredictor_fetch_meta), 32'h2140);
    chk("st1_tgt", bif.bpredictor_fetch_p_target, 32'h504);
    bif.fetch_bpredictor_PC = 32'h200;
    tick();
    chk("st2_meta", 32'(bif.bpredictor_fetch_meta), 32'h2140);
    chk("st2_tgt", bif.bpredictor_fetch_p_target, 32'h504);
    bif.fetch_bpredictor_PC = 32'h300;
    tick();
    chk("st3_meta", 32'(bif.bpredictor_fetch_meta), 32'h2140);
    chk("st3_dir", 32'(bif.bpredictor_fetch_p_dir), 32'd0);
    bif.soin_bpredictor_stall = 1'b0;
    bif.fetch_bpredictor_PC   = 32'h500;
    tick();
    chk("post_meta", 32'(bif.bpredictor_fetch_meta), 32'h1140);
    chk("post_tgt", bif.bpredictor_fetch_p_target, 32'h504);
`ifdef BP_STATS_EN
    chk("st_upd", bif.stat_updates, 32'(exp_upd));
    chk("st_miss", bif.stat_misses, 32'(exp_miss));
`endif

    bif.fetch_bpredictor_PC = 32'h100;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (2000) tick();
    chk("mid_busy", 32'(bif.bpredictor_busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
`ifdef BP_STATS_EN
    chk("st_rst_upd", bif.stat_updates, 32'd0);
    chk("st_rst_miss", bif.stat_misses, 32'd0);
`endif
    wait_init(0, 4000, n);
    chk("rbusy_len", 32'(n), 32'd4096);
    tick();
    chk("clr_meta", 32'(bif.bpredictor_fetch_meta), 32'h1040);
    chk("clr_dir", 32'(bif.bpredictor_fetch_p_dir), 32'd0);
    chk("clr_tgt", bif.bpredictor_fetch_p_target, 32'h104);
`ifdef BP_STATS_EN
    chk("st_drop_upd", bif.stat_updates, 32'd0);
`endif

    chk("g_meta0", 32'(gif.bpredictor_fetch_meta), 32'h1000);
    gif.execute_bpredictor_update = 1'b1;
    gif.execute_bpredictor_PC     = 32'h0;
    gif.execute_bpredictor_target = 32'h80;
    gif.execute_bpredictor_dir    = 1'b1;
    gif.execute_bpredictor_meta   = 15'h13FF;
    tick();
    chk("g_metaA", 32'(gif.bpredictor_fetch_meta), 32'h1000);
    tick();
    gif.execute_bpredictor_update = 1'b0;
    chk("g_metaB", 32'(gif.bpredictor_fetch_meta), 32'h5001);
    tick();
    chk("g_idx3", 32'(gif.bpredictor_fetch_meta[11:0]), 32'd3);
    chk("g_meta3", 32'(gif.bpredictor_fetch_meta), 32'h5003);
    chk("g_dir", 32'(gif.bpredictor_fetch_p_dir), 32'd0);
    chk("g_tgt", gif.bpredictor_fetch_p_target, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
